// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: accepts PC fetches over valid/ready and returns the
// word (or an error for misaligned/out-of-range addresses) after a fixed latency.
module instr_mem_responder #(
  parameter int          DEPTH       = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [31:0] Addr,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [31:0] Instr,
  output logic        RspErr,
  input  logic        LoadEn,
  input  logic [31:0] LoadAddr,
  input  logic [31:0] LoadData
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [29:0]   idx_q, idx_d;
  logic          err_q, err_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   mem_q [DEPTH];

  logic          load_ok;
  logic          req_err;

  assign ReqReady = (state_q == IDLE) && !Reset;
  assign RspValid = rsp_valid_q;
  assign RspErr   = rsp_err_q;
  assign Instr    = instr_q;

  assign req_err = (Addr[1:0] != 2'b00) || ({2'b00, Addr[31:2]} >= DEPTH_U);
  assign load_ok = LoadEn && !Reset && ({2'b00, LoadAddr[31:2]} < DEPTH_U);

  // Counter holds the number of extra WAIT cycles left; capture happens when it reaches zero,
  // so the capture edge is LATENCY edges after the accept edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    instr_d     = instr_q;
    case (state_q)
      IDLE: begin
        if (ReqValid) begin
          idx_d   = Addr[31:2];
          err_d   = req_err;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          if (err_q) begin
            instr_d   = 32'h0;
            rsp_err_d = 1'b1;
          end else begin
            instr_d   = mem_q[idx_q[AW-1:0]];
            rsp_err_d = 1'b0;
          end
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (RspReady) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      instr_q     <= RESET_INSTR;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      instr_q     <= instr_d;
    end
  end

  // Captured request fields only matter while a request is pending, so they carry no reset.
  always_ff @(posedge CLK) begin
    idx_q <= idx_d;
    err_q <= err_d;
  end

  always_ff @(posedge CLK) begin
    if (load_ok) mem_q[LoadAddr[AW+1:2]] <= LoadData;
  end

endmodule
